// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage.
// Optional hit/miss counters are enabled with `define DCACHE_STATS_EN.
module dcache_ctrl #(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  output logic [31:0]       rdata,
  output logic              dcache_stall,
  output logic              mm_req_valid,
  input  logic              mm_req_ready,
  output logic              mm_req_we,
  output logic [ADDR_W-1:0] mm_req_addr,
  output logic [31:0]       mm_req_wdata,
  output logic [3:0]        mm_req_wstrb,
  input  logic              mm_resp_valid,
  input  logic [31:0]       mm_resp_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS - 2;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t            state;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [31:0]       data_arr [LINES];
  logic              op_we;
  logic [31:0]       fill_q;
  logic [31:0]       rdata_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_W-1:0]      tag_in;
  logic                  hit;
  logic                  rd_hit;
  logic                  need_mem;
  logic                  accept;

  assign idx      = addr[INDEX_BITS+1:2];
  assign tag_in   = addr[ADDR_W-1:INDEX_BITS+2];
  assign hit      = valid_q[idx] && (tag_arr[idx] == tag_in);
  // A simultaneous read and write is handled as a write.
  assign rd_hit   = (state == IDLE) && mem_read && !mem_write && hit;
  assign need_mem = (state == IDLE) && (mem_write || (mem_read && !hit));
  assign accept   = mm_req_valid && mm_req_ready;

  // Stall must rise in the same cycle as a miss so the pipeline never advances past it.
  assign dcache_stall = need_mem || (state == REQ) || (state == WAIT);

  always_comb begin
    rdata = rdata_q;
    if (rd_hit)
      rdata = data_arr[idx];
    else if ((state == DONE) && !op_we)
      rdata = fill_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      valid_q      <= '0;
      op_we        <= 1'b0;
      fill_q       <= '0;
      rdata_q      <= '0;
      mm_req_valid <= 1'b0;
      mm_req_we    <= 1'b0;
      mm_req_addr  <= '0;
      mm_req_wdata <= '0;
      mm_req_wstrb <= '0;
    end else begin
      rdata_q <= rdata;
      case (state)
        IDLE: begin
          if (need_mem) begin
            op_we        <= mem_write;
            mm_req_valid <= 1'b1;
            mm_req_we    <= mem_write;
            mm_req_addr  <= addr & ~ADDR_W'(3);
            mm_req_wdata <= wdata;
            mm_req_wstrb <= mem_write ? wstrb : 4'hF;
            state        <= REQ;
          end
        end
        REQ: begin
          if (accept) begin
            mm_req_valid <= 1'b0;
            state        <= op_we ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (mm_resp_valid) begin
            valid_q[idx] <= 1'b1;
            fill_q       <= mm_resp_rdata;
            state        <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data storage carries no reset; only the valid bits qualify it.
  always_ff @(posedge clk) begin
    if ((state == WAIT) && mm_resp_valid) begin
      tag_arr[idx]  <= tag_in;
      data_arr[idx] <= mm_resp_rdata;
    end else if ((state == REQ) && accept && op_we && hit) begin
      for (int b = 0; b < 4; b++)
        if (wstrb[b]) data_arr[idx][8*b +: 8] <= wdata[8*b +: 8];
    end
  end

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if ((state == IDLE) && mem_read && !mem_write) begin
      if (hit) hit_cnt  <= hit_cnt + 32'd1;
      else     miss_cnt <= miss_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage.
- Produces dcache_stall toward the pipeline stall controller. While dcache_stall=1 the stall controller freezes PC, IF/ID, ID/EX and EX/MEM, so MEM-stage inputs stay stable.
- Talks to main memory over a valid/ready request channel and a valid-only response channel.
- One word (32 bit) per line.

Parameters:
- INDEX_BITS, 4, log2 of line count (16 lines); tag = addr[31:INDEX_BITS+2].
- ADDR_W, 32, address width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  MEM-stage load
- mem_write  in  1  MEM-stage store
- addr  in  ADDR_W  byte address; addr[1:0] ignored
- wdata  in  32  store data
- wstrb  in  4  store byte enables
- rdata  out  32  load data
- dcache_stall  out  1  hold pipeline
- mm_req_valid  out  1  memory request valid
- mm_req_ready  in  1  memory accepts request
- mm_req_we  out  1  1=write, 0=read
- mm_req_addr  out  ADDR_W  {addr[ADDR_W-1:2],2'b00}
- mm_req_wdata  out  32  store data
- mm_req_wstrb  out  4  byte enables (4'hF for reads)
- mm_resp_valid  in  1  read data valid (one cycle)
- mm_resp_rdata  in  32  read data

Behaviour:
- Reset (async, rst_n=0):
  - all valid bits cleared; state=IDLE.
  - mm_req_valid=0, mm_req_we=0, mm_req_addr=0, mm_req_wdata=0, mm_req_wstrb=0.
  - rdata=0, dcache_stall=0.
  - Tag/data arrays are not reset.
- Lookup: index=addr[INDEX_BITS+1:2]; hit = valid[index] && tag[index]==addr tag.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - mem_read && hit: rdata=data[index] combinationally, dcache_stall=0, stay IDLE (zero-stall hit).
  - mem_read && miss: dcache_stall=1 combinationally, latch op=read, go REQ.
  - mem_write (hit or miss): dcache_stall=1, latch op=write, go REQ.
  - mem_read && mem_write both 1: treated as write.
  - Neither asserted: dcache_stall=0, rdata holds last value.
- REQ:
  - mm_req_valid=1; request fields driven from current inputs (held stable by the stall); dcache_stall=1.
  - On mm_req_valid && mm_req_ready:
    - read → WAIT.
    - write → update line bytes per wstrb if it hits (no allocate on miss), then → DONE.
  - mm_req_valid and request fields must not change while ready=0.
- WAIT:
  - mm_req_valid=0, dcache_stall=1.
  - On mm_resp_valid: write tag, data and valid=1 at index; capture mm_resp_rdata into fill register; → DONE.
- DONE:
  - dcache_stall=0; rdata=fill register for reads; pipeline advances at end of cycle; → IDLE unconditionally.
  - Access inputs are not re-evaluated in DONE.
- Timing:
  - Read miss with ready=1 and response one cycle after accept: stall 3 cycles (IDLE, REQ, WAIT); data in DONE.
  - Write with ready=1: stall 2 cycles.
- mm_resp_valid outside WAIT is ignored, including stray responses after reset mid-operation.
- Reset mid-operation aborts any request; outstanding memory response is dropped.
- Only one outstanding request at a time.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - hit_cnt increments on each IDLE read hit; miss_cnt increments on each IDLE read miss.
  - Writes not counted. Counters wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Test Plan:
- After reset, read addr 0x0000_0040, ready=1, resp 1 cycle later with 0xDEADBEEF → stall high 3 cycles, rdata=0xDEADBEEF in DONE, mm_req_addr=0x40, we=0.
- Repeat read 0x40 → stall 0 same cycle, rdata=0xDEADBEEF, no mm_req_valid.
- Write 0x40 wdata=0x11223344 wstrb=4'b0011 → one request we=1 wstrb=0011; next read 0x40 hits with rdata=0xDEAD3344.
- Write miss 0x80 then read 0x80 → read misses (no allocate), goes to memory.
- Read 0x400 (same index as 0x0, different tag) after 0x0 cached → miss, line replaced; re-read 0x0 misses. Hold ready=0 for 5 cycles in REQ → request fields stable, stall held, total stall 8 cycles.
- Assert rst_n=0 in WAIT, then deliver mm_resp_valid → ignored, all valid bits 0, dcache_stall=0; with DCACHE_STATS_EN, hit_cnt=miss_cnt=0.
